// File: rtl/ram_wait_ctrl.sv
// Single-port synchronous RAM with a memio/rw request, programmable wait states and a one-cycle ready pulse.
// Define RAM_CLEAR_EN to build the power-up sweep that fills the array with CLEAR_VALUE after reset.
module ram_wait_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memio,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
        $error("ram_wait_ctrl: WAIT_STATES=%0d outside 0..15", WAIT_STATES);
    end

`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_CLEAR} state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
    logic [ADDR_WIDTH-1:0] ptr_reg;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;
    localparam state_t RESET_STATE = ST_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic                  rw_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  ready_reg;
    logic                  busy_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // The array access happens on the edge that enters ACK; with no wait states that is
    // the sampling edge itself, so the live inputs are used instead of the latched copy.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_reg;
        mem_wdata = wdata_reg;
        rd_en     = 1'b0;
        rd_addr   = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (memio && NO_WAIT) begin
                    mem_we    = !rw;
                    mem_waddr = addr;
                    mem_wdata = wdata;
                    rd_en     = rw;
                    rd_addr   = addr;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    mem_we = !rw_reg;
                    rd_en  = rw_reg;
                end
            end
`ifdef RAM_CLEAR_EN
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_reg;
                mem_wdata = CLEAR_VALUE;
            end
`endif
            default: ;
        endcase
        // A write must never land while reset is held, or an aborted request would leak through.
        mem_we = mem_we & rst_n;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= 4'd0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= RESET_BUSY;
`ifdef RAM_CLEAR_EN
            ptr_reg   <= '0;
`endif
        end else begin
            ready_reg <= 1'b0;
            if (rd_en) begin
                rdata_reg <= mem[rd_addr];
            end
            case (state_reg)
                ST_IDLE: begin
                    if (memio) begin
                        rw_reg    <= rw;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        busy_reg  <= 1'b1;
                        if (NO_WAIT) begin
                            state_reg <= ST_ACK;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= WS_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_ACK;
                        ready_reg <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
`ifdef RAM_CLEAR_EN
                ST_CLEAR: begin
                    ptr_reg <= ptr_reg + ADDR_WIDTH'(1);
                    if (ptr_reg == '1) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign ready = ready_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Scoreboard bench for ram_wait_ctrl: one instance per wait-state setting, each with its own
// driver pushing expectations and a monitor popping them on every ready pulse.
module tb_ram_wait_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 2 ** AW;
    localparam int NBLK = 4;
`ifdef RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        int            target;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string nm, input int ws, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL ws=%0d %s: got %0h expected %0h", ws, nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
        localparam int WS = ws_of(gi);

        logic          rst_n = 1'b1;
        logic          memio = 1'b0;
        logic          rw = 1'b0;
        logic [AW-1:0] addr = '0;
        logic [DW-1:0] wdata = '0;
        logic [DW-1:0] rdata;
        logic          ready;
        logic          busy;

        exp_t          q[$];
        int            ncyc = 0;
        logic          sweeping = CLR;
        logic [DW-1:0] last_rd = '0;
        logic [DW-1:0] model [DEPTH];
        bit            known [DEPTH];

        ram_wait_ctrl #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .WAIT_STATES(WS),
            .CLEAR_VALUE(8'h3C)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .memio(memio),
            .rw   (rw),
            .addr (addr),
            .wdata(wdata),
            .rdata(rdata),
            .ready(ready),
            .busy (busy)
        );

        // Monitor: busy must track outstanding work, rdata must hold, each ready retires one entry.
        always @(negedge clk) begin : mon
            exp_t e;
            ncyc++;
            chk("busy", WS, 32'(busy), 32'(sweeping || q.size() > 0));
            if (ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ws=%0d ready_unexpected: got ready=1 expected no pending request", WS);
                end else begin
                    e = q.pop_front();
                    chk("ready_cycle", WS, ncyc, e.target);
                    if (e.rd) begin
                        chk("rdata", WS, rdata, e.data);
                        last_rd = e.data;
                    end else begin
                        chk("rdata_keep", WS, rdata, last_rd);
                    end
                    $display("ws=%0d cyc=%0d %s addr=%02h data=%02h rdata=%02h",
                             WS, ncyc, e.rd ? "RD" : "WR", e.addr, e.data, rdata);
                end
            end else begin
                chk("rdata_hold", WS, rdata, last_rd);
                if (q.size() > 0 && ncyc > q[0].target) begin
                    checks++;
                    errors++;
                    $display("FAIL ws=%0d ready_missing: got no ready by cycle %0d expected at cycle %0d",
                             WS, ncyc, q[0].target);
                    void'(q.pop_front());
                end
            end
        end

        task automatic do_reset();
            sweeping = CLR;
            rst_n = 1'b0;
            q.delete();
            last_rd = '0;
            #1;
            chk("rst_ready", WS, 32'(ready), 0);
            chk("rst_busy", WS, 32'(busy), 32'(CLR));
            chk("rst_rdata", WS, rdata, 0);
            memio = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
            memio = 1'b1;
            rw = 1'b0;
            addr = 8'h00;
            wdata = 8'hEE;
            repeat (DEPTH - 1) @(posedge clk);
            @(negedge clk);
            memio = 1'b0;
            @(posedge clk);
            sweeping = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                model[i] = 8'h3C;
                known[i] = 1'b1;
            end
`endif
        endtask

        // memio stays high for 'hold' edges; IDLE re-samples it every WS+2 edges.
        task automatic req(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
            int   last_s;
            int   n;
            exp_t x;
            last_s = 0;
            @(negedge clk);
            memio = 1'b1;
            rw = r;
            addr = a;
            wdata = d;
            for (int e = 0; e < hold; e++) begin
                @(posedge clk);
                if (e % (WS + 2) == 0) begin
                    x.target = ncyc + WS + 1;
                    x.rd = r;
                    x.addr = a;
                    if (r) begin
                        x.data = model[a];
                    end else begin
                        x.data = d;
                        model[a] = d;
                        known[a] = 1'b1;
                    end
                    q.push_back(x);
                    last_s = e;
                end
            end
            @(negedge clk);
            memio = 1'b0;
            addr = ~a;
            wdata = ~d;
            n = last_s + WS + 2 - hold;
            repeat (n) @(posedge clk);
        endtask

        initial begin : drv
            logic [AW-1:0] a;
            int            k;
            #1;
            do_reset();
`ifdef RAM_CLEAR_EN
            req(1'b1, 8'h00, 8'h00, 1);
            req(1'b1, 8'hFF, 8'h00, 1);
`endif
            req(1'b0, 8'h10, 8'hA5, 1);
            req(1'b1, 8'h10, 8'h00, 1);
            req(1'b0, 8'h00, 8'h11, 1);
            req(1'b0, 8'h01, 8'h22, 1);
            req(1'b1, 8'h00, 8'h00, 1);
            req(1'b1, 8'h01, 8'h00, 1);
            req(1'b0, 8'h03, 8'h44, WS + 2);
            req(1'b1, 8'h01, 8'h00, WS + 3);
            req(1'b0, 8'h02, 8'h33, WS + 3);
            req(1'b1, 8'h02, 8'h00, 1);
            req(1'b1, 8'h03, 8'h00, 1);
            // Abort a write to 0x20 with reset: before the sampling edge when there is no
            // wait state, otherwise while the request sits in WAIT.
            req(1'b0, 8'h20, 8'h77, 1);
            @(negedge clk);
            memio = 1'b1;
            rw = 1'b0;
            addr = 8'h20;
            wdata = 8'h5A;
            k = (WS == 0) ? 0 : 1;
            repeat (k) @(posedge clk);
            #2;
            do_reset();
            req(1'b1, 8'h20, 8'h00, 1);
            for (int i = 0; i < 12; i++) begin
                a = 8'h40 + 8'((i * 5) % 8);
                req((i % 3 != 0) && known[a], a, 8'((i * 37 + 1) % 256), 1 + (i % 2) * (WS + 3));
            end
            for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
            chk("queue_drained", WS, q.size(), 0);
            done_cnt++;
        end
    end

    initial begin : top
        int n;
        n = 0;
        while (done_cnt < NBLK && n < 30000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < NBLK) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d finished drivers expected %0d", done_cnt, NBLK);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
